// File: rtl/int_ram_pkg.sv
// Shared types and constants for the INT_RAM ping-pong controller.
// Bank indices match the INT_RAM port numbering (1 and 2).
package int_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  typedef logic [1:0] bank_idx_t;

  localparam bank_idx_t BANK_A = 2'd1;
  localparam bank_idx_t BANK_B = 2'd2;

  function automatic bank_idx_t bank_toggle(input bank_idx_t bank);
    return (bank == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/int_ram_bank_fsm.sv
// Per-bank ownership state: EMPTY -> FILLING -> FULL while written,
// back to EMPTY when the decoder releases it.
module int_ram_bank_fsm
  import int_ram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_accept,
  input  logic        wr_last,
  input  logic        rd_release,
  output bank_state_t state
);

  // Release and write never target the same bank: writes need EMPTY/FILLING,
  // release needs FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else if (rd_release) begin
      state <= EMPTY;
    end else if (wr_accept) begin
      state <= wr_last ? FULL : FILLING;
    end
  end

endmodule

// File: rtl/int_ram_pingpong_ctrl.sv
// Ping-pong write/read controller in front of the two INT_RAM banks.
// Optional macro INT_RAM_CTRL_ERR_EN adds the err_sticky output.
module int_ram_pingpong_ctrl
  import int_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int N_LLR      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  frame_ready,
  input  logic                  dec_rd_en,
  input  logic [ADDR_WIDTH-1:0] dec_rd_addr,
  output logic [DATA_WIDTH-1:0] dec_rd_data,
  output logic                  dec_rd_valid,
  input  logic                  dec_done,
  output logic [DATA_WIDTH-1:0] ram_data_in  [2:1],
  output logic [ADDR_WIDTH-1:0] ram_address  [2:1],
  output logic                  ram_chip_sel [2:1],
  output logic                  ram_write_en [2:1],
  input  logic [DATA_WIDTH-1:0] ram_data_out [2:1]
`ifdef INT_RAM_CTRL_ERR_EN
  ,
  output logic                  err_sticky
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(N_LLR - 1);
  localparam logic [ADDR_WIDTH:0]   N_LIMIT  = (ADDR_WIDTH + 1)'(N_LLR);

  bank_state_t           bank_state [2:1];
  bank_idx_t             wr_bank_reg;
  bank_idx_t             rd_bank_reg;
  bank_idx_t             rd_bank_q_reg;
  logic [ADDR_WIDTH-1:0] wr_cnt_reg;
  logic                  rd_valid_reg;

  bank_state_t wr_state;
  bank_state_t rd_state;
  logic        wr_accept;
  logic        wr_last;
  logic        rd_accept;
  logic        rd_release;
  logic        addr_ok;

  assign wr_state = (wr_bank_reg == BANK_B) ? bank_state[2] : bank_state[1];
  assign rd_state = (rd_bank_reg == BANK_B) ? bank_state[2] : bank_state[1];

  assign in_ready    = !rst && (wr_state != FULL);
  assign frame_ready = (rd_state == FULL);
  assign addr_ok     = ({1'b0, dec_rd_addr} < N_LIMIT);

  assign wr_accept  = in_valid && in_ready;
  assign wr_last    = (wr_cnt_reg == LAST_CNT);
  assign rd_accept  = !rst && dec_rd_en && frame_ready && addr_ok;
  assign rd_release = !rst && dec_done && frame_ready;

  generate
    for (genvar gi = 1; gi <= 2; gi++) begin : g_bank
      logic wr_hit;
      logic rd_hit;

      assign wr_hit = wr_accept && (wr_bank_reg == bank_idx_t'(gi));
      assign rd_hit = rd_accept && (rd_bank_reg == bank_idx_t'(gi));

      int_ram_bank_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .wr_accept  (wr_hit),
        .wr_last    (wr_last),
        .rd_release (rd_release && (rd_bank_reg == bank_idx_t'(gi))),
        .state      (bank_state[gi])
      );

      // A bank is either being filled or being read, never both.
      assign ram_chip_sel[gi] = wr_hit || rd_hit;
      assign ram_write_en[gi] = wr_hit;
      assign ram_address[gi]  = wr_hit ? wr_cnt_reg :
                                rd_hit ? dec_rd_addr : '0;
      assign ram_data_in[gi]  = wr_hit ? in_data : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg   <= BANK_A;
      rd_bank_reg   <= BANK_A;
      rd_bank_q_reg <= BANK_A;
      wr_cnt_reg    <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      rd_valid_reg  <= rd_accept;
      rd_bank_q_reg <= rd_bank_reg;
      if (wr_accept) begin
        if (wr_last) begin
          wr_cnt_reg  <= '0;
          wr_bank_reg <= bank_toggle(wr_bank_reg);
        end else begin
          wr_cnt_reg  <= wr_cnt_reg + 1'b1;
        end
      end
      if (rd_release) begin
        rd_bank_reg <= bank_toggle(rd_bank_reg);
      end
    end
  end

  // The bank captured at accept keeps a read coincident with dec_done on the old bank.
  assign dec_rd_valid = rd_valid_reg;
  assign dec_rd_data  = !rd_valid_reg ? '0 :
                        (rd_bank_q_reg == BANK_B) ? ram_data_out[2] : ram_data_out[1];

`ifdef INT_RAM_CTRL_ERR_EN
  logic err_sticky_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
    end else if ((dec_rd_en && !rd_accept) || (dec_done && !frame_ready)) begin
      err_sticky_reg <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_reg;
`endif

endmodule

// File: tb/tb_int_ram_pingpong_ctrl.sv
// Self-checking bench: frame-queue reference model plus a behavioural INT_RAM pair.
module tb_int_ram_pingpong_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          frame_ready;
  logic          dec_rd_en;
  logic [AW-1:0] dec_rd_addr;
  logic [DW-1:0] dec_rd_data;
  logic          dec_rd_valid;
  logic          dec_done;
  logic [DW-1:0] ram_data_in  [2:1];
  logic [AW-1:0] ram_address  [2:1];
  logic          ram_chip_sel [2:1];
  logic          ram_write_en [2:1];
  logic [DW-1:0] ram_data_out [2:1];
`ifdef INT_RAM_CTRL_ERR_EN
  logic          err_sticky;
`endif

  always #5 clk = ~clk;

  int_ram_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_LLR(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .frame_ready  (frame_ready),
    .dec_rd_en    (dec_rd_en),
    .dec_rd_addr  (dec_rd_addr),
    .dec_rd_data  (dec_rd_data),
    .dec_rd_valid (dec_rd_valid),
    .dec_done     (dec_done),
    .ram_data_in  (ram_data_in),
    .ram_address  (ram_address),
    .ram_chip_sel (ram_chip_sel),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out)
`ifdef INT_RAM_CTRL_ERR_EN
    ,
    .err_sticky   (err_sticky)
`endif
  );

  // Behavioural INT_RAM banks: synchronous write, registered read.
  logic [DW-1:0] mem [2:1][0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int p = 1; p <= 2; p++) begin
      if (ram_chip_sel[p]) begin
        if (ram_write_en[p]) mem[p][ram_address[p]] <= ram_data_in[p];
        else                 ram_data_out[p] <= mem[p][ram_address[p]];
      end
    end
  end

  // Reference model: a queue of completed frames (front = decoder-owned),
  // the words of the frame being filled, and frames written since reset.
  typedef logic [DW-1:0] frame_t [N];
  frame_t        full_q[$];
  int            full_bank[$];
  logic [DW-1:0] fill_q[$];
  int            frame_cnt;
  bit            err_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input bit re, input logic [AW-1:0] ra, input bit dn);
    bit            wr_acc, rd_acc, rdy_e, hit_w, hit_r;
    int            nfull, wb, rb;
    logic [DW-1:0] rexp;
    frame_t        fr;
    rst = r; in_valid = v; in_data = d;
    dec_rd_en = re; dec_rd_addr = ra; dec_done = dn;
    #1;
    nfull = full_q.size();
    rdy_e = !r && (nfull < 2);
    check_val("in_ready", in_ready, rdy_e);
    if (!r) check_val("frame_ready", frame_ready, nfull > 0);
    wr_acc = v && rdy_e;
    wb     = 1 + (frame_cnt % 2);
    rd_acc = !r && re && (nfull > 0) && (ra < N);
    rb     = (nfull > 0) ? full_bank[0] : 1;
    rexp   = rd_acc ? full_q[0][ra] : '0;
    for (int p = 1; p <= 2; p++) begin
      hit_w = wr_acc && (wb == p);
      hit_r = rd_acc && (rb == p);
      check_val($sformatf("chip_sel%0d", p), ram_chip_sel[p], hit_w || hit_r);
      check_val($sformatf("write_en%0d", p), ram_write_en[p], hit_w);
      check_val($sformatf("address%0d", p), ram_address[p],
                hit_w ? fill_q.size() : hit_r ? ra : 0);
      check_val($sformatf("data_in%0d", p), ram_data_in[p], hit_w ? d : 0);
    end
    if (wr_acc) $display("wr  bank=%0d addr=%0d data=%0d", wb, fill_q.size(), d);
    @(posedge clk);
    #1;
    check_val("rd_valid", dec_rd_valid, rd_acc);
    if (rd_acc) begin
      check_val("rd_data", dec_rd_data, rexp);
      $display("rd  bank=%0d addr=%0d data=%0d", rb, ra, dec_rd_data);
    end
    if (r) begin
      check_val("rd_data_rst", dec_rd_data, 0);
      full_q.delete(); full_bank.delete(); fill_q.delete();
      frame_cnt = 0;
      err_m = 0;
    end else begin
      if ((re && !rd_acc) || (dn && nfull == 0)) err_m = 1;
      if (dn && nfull > 0) begin
        void'(full_q.pop_front());
        void'(full_bank.pop_front());
      end
      if (wr_acc) begin
        fill_q.push_back(d);
        if (fill_q.size() == N) begin
          for (int i = 0; i < N; i++) fr[i] = fill_q[i];
          full_q.push_back(fr);
          full_bank.push_back(wb);
          fill_q.delete();
          frame_cnt++;
        end
      end
    end
`ifdef INT_RAM_CTRL_ERR_EN
    check_val("err_sticky", err_sticky, err_m);
`endif
  endtask

  initial begin
    frame_cnt = 0;
    err_m = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 8'hAA, 1, 0, 1);

    // Frame 1 into bank 1, then frame_ready follows.
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(10 * i), 0, 0, 0);
    // Reads 3,0,2 back-to-back.
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 2, 0);
    // Frame 2 fills bank 2 while frame 1 is read.
    for (int i = 5; i <= 8; i++) step(0, 1, 8'(10 * i), 1, 8'(i - 5), 0);
    step(0, 1, 90, 0, 0, 0);
    step(0, 1, 90, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 90, 0, 0, 0);

    // Rejected reads: out of range, and with nothing full.
    step(0, 0, 0, 1, 5, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // Final write of bank 2 coincident with dec_done of bank 1.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(100 + i), 0, 0, 0);
    step(0, 1, 107, 0, 0, 1);
    step(0, 1, 108, 1, 2, 0);

    // Reset after 2 of 4 writes: the partial frame is discarded.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom),
           $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 5)),
           $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
